baggage_drop_seq: RTL
=====================

# baggage_drop_seq

Sequential, parametrised successor of the helicopter baggage-drop decision path. On a start pulse it fuses N altitude sensors, ignoring zero readings, into an average height. It then computes t_act = sqrt(h)/2 in fixed point with a multi-cycle iterative root, compares t_act against t_lim, and registers the drop decision and four seven-segment digits. It sits between the sensor acquisition front end and the cockpit display/drop actuator.

## Interface
- N_SENSORS, 4: number of altitude sensors, 2..16
- SENSOR_W, 8: sensor reading width, even, 4..16
- FRAC_W, 8: fractional bits of root and t_act
- T_W, 16: width of t_lim and t_act, must be at least SENSOR_W/2+FRAC_W
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to sample sensors and evaluate
- sensors  in  N_SENSORS*SENSOR_W  packed readings, sensor i at bits [i*SENSOR_W +: SENSOR_W]; value 0 means faulty
- t_lim  in  T_W  time limit, same fixed-point format as t_act
- drop_en  in  1  pilot drop enable
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when results update
- err  out  1  all sensors read 0 in the last evaluation
- t_act  out  T_W  last computed sqrt(h)/2
- drop_activated  out  1  drop decision
- seven_seg1..seven_seg4  out  7 each  digit segments, bit order gfedcba, active-high, seven_seg1 leftmost

## Operation
- FSM states: IDLE, ACCUM, DIV, SQRT, EVAL.
- IDLE:
  - start captures sensors, t_lim and drop_en into internal registers, then moves to ACCUM.
  - start while busy is ignored.
- ACCUM: one sensor per cycle, index 0 first. A non-zero reading is added to sum (SUM_W = SENSOR_W+clog2(N_SENSORS)) and increments cnt. Lasts N_SENSORS cycles.
- DIV:
  - Restoring division h = floor(sum/cnt), SUM_W cycles.
  - If cnt==0, the divider still runs with h forced to 0 and err_next set to 1.
- SQRT:
  - Bit-serial integer square root of h·2^(2·FRAC_W).
  - Runs ROOT_W = SENSOR_W/2+FRAC_W cycles.
  - root = floor(sqrt(h)·2^FRAC_W).
- EVAL, 1 cycle:
  - t_act_next = root>>1 (truncating), zero-extended to T_W.
  - drop_next = drop_en_captured && !err_next && (t_act_next <= t_lim_captured).
  - All outputs are registered at the exit edge of EVAL; done pulses; the FSM returns to IDLE.
- Display:
  - err shows "Err-".
  - Otherwise drop_activated shows "drOP".
  - Otherwise t_act > t_lim shows "COLd".
  - Otherwise (in limit but drop_en low) shows "rdY-".
  - Display holds until the next done.
- Reset values: busy 0, done 0, err 0, t_act 0, drop_activated 0, all seven_seg 7'b0 (blank). FSM goes to IDLE. Reset mid-evaluation aborts it with no done pulse.

## Timing
- Latency LAT = N_SENSORS + SUM_W + ROOT_W + 1 cycles in non-IDLE states. Defaults: 4+10+12+1 = 27.
- done rises LAT cycles after the edge that samples start. Outputs change on the same edge.
- busy rises on the edge after start is sampled and falls on the same edge done rises. A new start is accepted in the cycle done is high, which gives back-to-back evaluations.
- Sensor, t_lim and drop_en changes after capture do not affect the running evaluation.
- Equality t_act == t_lim counts as in limit.

## Configuration
- BAGGAGE_DROP_LATCH_EN defined:
  - drop_activated is sticky: once set, it stays 1 across later evaluations until rst, or until drop_en is seen low at capture.
  - The display shows "drOP" while the latch is set.
- Not defined: drop_activated is recomputed at every EVAL.

## Structure
- Package baggage_drop_pkg holds:
  - the state enum;
  - the segment constants SEG_BLANK, SEG_C, SEG_O, SEG_L, SEG_D, SEG_R, SEG_P, SEG_E, SEG_Y, SEG_DASH;
  - clog2-based width helpers for SUM_W and ROOT_W.
- One sub-module: bd_isqrt, the iterative root core with start, done and a ROOT_W-bit result, parametrised by input width.

## Test plan
- Sensors 100,100,100,100; t_lim 0x0500; drop_en 1 -> h=100, t_act=0x0500, drop_activated=1, "drOP", done 27 cycles after start.
- Sensors 0,81,81,0; t_lim 0x0400; drop_en 1 -> t_act=0x0480, drop_activated=0, "COLd", err=0.
- Sensors 2,2,2,2; t_lim 0xFFFF; drop_en 0 -> root 0x16A, t_act=0x00B5, drop_activated=0, "rdY-".
- Sensors all 0 -> err=1, t_act=0, drop_activated=0, "Err-".
- rst asserted 10 cycles into an evaluation -> no done, all outputs 0 immediately. A start issued during busy is ignored.
- With BAGGAGE_DROP_LATCH_EN: one drop evaluation, then sensors 100 each with t_lim 0x0100 and drop_en 1 -> drop_activated stays 1. Next start with drop_en 0 -> drop_activated 0.

Source files
------------

// File: rtl/baggage_drop_pkg.sv
// Shared types, seven-segment glyphs and width helpers for the baggage-drop sequencer.
package baggage_drop_pkg;

  typedef enum logic [2:0] {IDLE, ACCUM, DIV, SQRT, EVAL} state_t;

  // Segment order gfedcba, active-high.
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_O     = 7'h3F;
  localparam logic [6:0] SEG_L     = 7'h38;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_R     = 7'h50;
  localparam logic [6:0] SEG_P     = 7'h73;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_Y     = 7'h6E;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  function automatic int sum_width(input int sensor_w, input int n_sensors);
    return sensor_w + $clog2(n_sensors);
  endfunction

  function automatic int root_width(input int sensor_w, input int frac_w);
    return sensor_w / 2 + frac_w;
  endfunction

endpackage

// File: rtl/baggage_drop_isqrt.sv
// Bit-serial integer square root: IN_W/2 iterations, two radicand bits per cycle.
module bd_isqrt #(
  parameter int IN_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IN_W-1:0]   radicand,
  output logic              done,
  output logic [IN_W/2-1:0] root
);
  localparam int ROOT_W = IN_W / 2;
  localparam int CW     = $clog2(ROOT_W + 1);

  logic [IN_W-1:0]   rad_q, rad_s;
  logic [ROOT_W:0]   rem_q, rem_s;
  logic [ROOT_W-1:0] root_s;
  logic [ROOT_W+2:0] acc, sub, diff;
  logic              ge;
  logic              running;
  logic [CW-1:0]     step;

  // The start cycle already performs the first iteration on the fresh radicand.
  always_comb begin
    rad_s  = start ? radicand : rad_q;
    rem_s  = start ? '0 : rem_q;
    root_s = start ? '0 : root;
    acc    = {rem_s, rad_s[IN_W-1 -: 2]};
    sub    = {1'b0, root_s, 2'b01};
    ge     = (acc >= sub);
    diff   = ge ? (acc - sub) : acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad_q   <= '0;
      rem_q   <= '0;
      root    <= '0;
      running <= 1'b0;
      step    <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start || running) begin
        rad_q <= rad_s << 2;
        rem_q <= diff[ROOT_W:0];
        root  <= {root_s[ROOT_W-2:0], ge};
      end
      if (start) begin
        running <= 1'b1;
        step    <= CW'(1);
      end else if (running) begin
        if (step == CW'(ROOT_W - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end else begin
          step <= step + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/baggage_drop_seq.sv
// Sequential baggage-drop decision: sensor fusion, divide, sqrt, limit compare, display.
// Define BAGGAGE_DROP_LATCH_EN to make drop_activated sticky until drop_en is captured low.
module baggage_drop_seq
  import baggage_drop_pkg::*;
#(
  parameter int N_SENSORS = 4,
  parameter int SENSOR_W  = 8,
  parameter int FRAC_W    = 8,
  parameter int T_W       = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [N_SENSORS*SENSOR_W-1:0]   sensors,
  input  logic [T_W-1:0]                  t_lim,
  input  logic                            drop_en,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic [T_W-1:0]                  t_act,
  output logic                            drop_activated,
  output logic [6:0]                      seven_seg1,
  output logic [6:0]                      seven_seg2,
  output logic [6:0]                      seven_seg3,
  output logic [6:0]                      seven_seg4
);
  localparam int SUM_W  = sum_width(SENSOR_W, N_SENSORS);
  localparam int ROOT_W = root_width(SENSOR_W, FRAC_W);
  localparam int CNT_W  = $clog2(N_SENSORS + 1);
  localparam int CYC_W  = $clog2(N_SENSORS + SUM_W + ROOT_W + 1);

  state_t                          state;
  logic [CYC_W-1:0]                cyc;
  logic [N_SENSORS*SENSOR_W-1:0]   sens_q;
  logic [T_W-1:0]                  t_lim_q;
  logic                            drop_en_q;
  logic [SUM_W-1:0]                quo;
  logic [CNT_W-1:0]                cnt, rem;

  logic [CNT_W:0]                  trial, rdiff;
  logic                            q_bit;
  logic [SENSOR_W-1:0]             h;
  logic [2*ROOT_W-1:0]             radicand;
  logic                            sq_start, sq_done;
  logic [ROOT_W-1:0]               root;
  logic [T_W-1:0]                  t_next;
  logic                            err_next, drop_next, drop_final;
  logic [27:0]                     seg_next;

  // quo holds the running sum during ACCUM and becomes the quotient during DIV.
  always_comb begin
    trial    = {rem, quo[SUM_W-1]};
    q_bit    = (trial >= {1'b0, cnt});
    rdiff    = q_bit ? (trial - {1'b0, cnt}) : trial;
    h        = (cnt == '0) ? '0 : quo[SENSOR_W-1:0];
    radicand = {h, {(2*FRAC_W){1'b0}}};
    sq_start = (state == SQRT) && (cyc == '0);
  end

  always_comb begin
    t_next    = T_W'(root >> 1);
    err_next  = (cnt == '0);
    drop_next = drop_en_q && !err_next && (t_next <= t_lim_q);
`ifdef BAGGAGE_DROP_LATCH_EN
    drop_final = drop_next || (drop_activated && drop_en_q);
`else
    drop_final = drop_next;
`endif
    if (err_next)
      seg_next = {SEG_E, SEG_R, SEG_R, SEG_DASH};
    else if (drop_final)
      seg_next = {SEG_D, SEG_R, SEG_O, SEG_P};
    else if (t_next > t_lim_q)
      seg_next = {SEG_C, SEG_O, SEG_L, SEG_D};
    else
      seg_next = {SEG_R, SEG_D, SEG_Y, SEG_DASH};
  end

  bd_isqrt #(.IN_W(2*ROOT_W)) u_isqrt (
    .clk      (clk),
    .rst      (rst),
    .start    (sq_start),
    .radicand (radicand),
    .done     (sq_done),
    .root     (root)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cyc            <= '0;
      sens_q         <= '0;
      t_lim_q        <= '0;
      drop_en_q      <= 1'b0;
      quo            <= '0;
      cnt            <= '0;
      rem            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      t_act          <= '0;
      drop_activated <= 1'b0;
      seven_seg1     <= SEG_BLANK;
      seven_seg2     <= SEG_BLANK;
      seven_seg3     <= SEG_BLANK;
      seven_seg4     <= SEG_BLANK;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sens_q    <= sensors;
            t_lim_q   <= t_lim;
            drop_en_q <= drop_en;
            quo       <= '0;
            cnt       <= '0;
            rem       <= '0;
            cyc       <= '0;
            busy      <= 1'b1;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          if (sens_q[SENSOR_W-1:0] != '0) begin
            quo <= quo + SUM_W'(sens_q[SENSOR_W-1:0]);
            cnt <= cnt + 1'b1;
          end
          sens_q <= sens_q >> SENSOR_W;
          if (cyc == CYC_W'(N_SENSORS - 1)) begin
            cyc   <= '0;
            state <= DIV;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        DIV: begin
          quo <= {quo[SUM_W-2:0], q_bit};
          rem <= rdiff[CNT_W-1:0];
          if (cyc == CYC_W'(SUM_W - 1)) begin
            cyc   <= '0;
            state <= SQRT;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        SQRT: begin
          if (cyc == CYC_W'(ROOT_W - 1)) begin
            cyc   <= '0;
            state <= EVAL;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        EVAL: begin
          if (sq_done) begin
            t_act          <= t_next;
            err            <= err_next;
            drop_activated <= drop_final;
            {seven_seg1, seven_seg2, seven_seg3, seven_seg4} <= seg_next;
            done           <= 1'b1;
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
